// File: rtl/from_axis_pkg.sv
// Shared types and entry layout for the AXIS-to-GEM TX FIFO read-port converter.
package from_axis_pkg;

    localparam int unsigned ENTRY_W  = 10;
    localparam int unsigned DATA_LSB = 0;
    localparam int unsigned LAST_BIT = 8;
    localparam int unsigned ERR_BIT  = 9;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SEND  = 2'd1,
        ST_FLUSH = 2'd2
    } rd_state_e;

endpackage

// File: rtl/fax_byte_fifo.sv
// Single-clock DEPTH x ENTRY_W entry FIFO with an in-place "close frame" update
// of the most recently written entry.
module fax_byte_fifo
    import from_axis_pkg::*;
#(
    parameter int unsigned DEPTH = 256
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  logic [ENTRY_W-1:0]     wdata_i,
    input  logic                   set_last_i,
    input  logic                   set_err_i,
    input  logic                   pop_i,
    output logic [ENTRY_W-1:0]     rdata_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] level_nxt_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]      wr_ptr_q, rd_ptr_q, prev_ptr;
    logic [AW:0]        level_q;
    logic               do_push, do_pop;

    assign empty_o  = (level_q == '0);
    assign do_push  = push_i && (level_q != FULL_LVL);
    assign do_pop   = pop_i && !empty_o;
    assign prev_ptr = wr_ptr_q - AW'(1);
    assign rdata_o  = mem_q[rd_ptr_q];

    always_comb begin
        level_nxt_o = level_q;
        case ({do_push, do_pop})
            2'b10:   level_nxt_o = level_q + (AW+1)'(1);
            2'b01:   level_nxt_o = level_q - (AW+1)'(1);
            default: level_nxt_o = level_q;
        endcase
    end

    // A discarded tlast beat closes the frame by patching the entry already stored.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end else if (set_last_i) begin
            mem_q[prev_ptr][LAST_BIT] <= 1'b1;
            if (set_err_i) begin
                mem_q[prev_ptr][ERR_BIT] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            level_q <= level_nxt_o;
        end
    end

endmodule

// File: rtl/from_axis_converter.sv
// AXI-Stream slave feeding the GEM external TX FIFO read port, plus the TX status toggle handshake.
// Optional cut-through start and underflow flush: define FROM_AXIS_CUT_THROUGH_EN.
module from_axis_converter
    import from_axis_pkg::*;
#(
    parameter int unsigned DEPTH     = 256,
    parameter int unsigned CT_THRESH = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] s_axis_tdata,
    input  logic       s_axis_tkeep,
    input  logic       s_axis_tvalid,
    input  logic       s_axis_tlast,
    input  logic       s_axis_tuser,
    output logic       s_axis_tready,
    input  logic       tx_r_rd,
    output logic       tx_r_data_rdy,
    output logic       tx_r_valid,
    output logic [7:0] tx_r_data,
    output logic       tx_r_sop,
    output logic       tx_r_eop,
    output logic       tx_r_err,
    output logic       tx_r_underflow,
    output logic       tx_r_flushed,
    output logic       tx_r_control,
    input  logic       dma_tx_end_tog,
    input  logic [3:0] tx_r_status,
    output logic       dma_tx_status_tog,
    output logic [3:0] tx_status,
    output logic       tx_status_valid
);

    localparam int unsigned LW = $clog2(DEPTH) + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    if (DEPTH < 16 || (DEPTH & (DEPTH - 1)) != 0 || CT_THRESH >= DEPTH) begin : g_bad_cfg
        $error("from_axis_converter: DEPTH must be a power of 2 >= 16 and CT_THRESH < DEPTH");
    end

    logic               tready_q, tready_d;
    logic               open_q, open_d;
    logic               err_stk_q, err_stk_d;
    logic [LW-1:0]      frame_cnt_q, frame_cnt_d;
    logic               data_rdy_q, data_rdy_d;
    rd_state_e          state_q, state_d;

    logic               beat, wr_kept, merge_last, frame_end, err_acc;
    logic               pop, empty, is_last;
    logic [ENTRY_W-1:0] wdata, rdata;
    logic [LW-1:0]      level_nxt;

    logic               vld_d, sop_d, eop_d, err_d, uf_d, fl_d;
    logic [7:0]         data_d;

    logic               end_tog_q, status_valid_q, status_tog_q, end_edge;
    logic [3:0]         status_q;

    assign beat       = s_axis_tvalid && tready_q;
    assign wr_kept    = beat && s_axis_tkeep;
    assign merge_last = beat && !s_axis_tkeep && s_axis_tlast && open_q && !empty;
    assign frame_end  = (wr_kept && s_axis_tlast) || merge_last;
    assign err_acc    = err_stk_q || s_axis_tuser;
    assign wdata      = {err_acc && s_axis_tlast, s_axis_tlast, s_axis_tdata};
    assign is_last    = rdata[LAST_BIT];

    fax_byte_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (wr_kept),
        .wdata_i     (wdata),
        .set_last_i  (merge_last),
        .set_err_i   (err_acc),
        .pop_i       (pop),
        .rdata_o     (rdata),
        .empty_o     (empty),
        .level_nxt_o (level_nxt)
    );

    always_comb begin
        tready_d  = (level_nxt != FULL_LVL);
        open_d    = open_q;
        err_stk_d = err_stk_q;
        if (frame_end)    open_d = 1'b0;
        else if (wr_kept) open_d = 1'b1;
        if (beat && s_axis_tlast)      err_stk_d = 1'b0;
        else if (beat && s_axis_tuser) err_stk_d = 1'b1;
    end

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        vld_d   = 1'b0;
        data_d  = '0;
        sop_d   = 1'b0;
        eop_d   = 1'b0;
        err_d   = 1'b0;
        uf_d    = 1'b0;
        fl_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (tx_r_rd && data_rdy_q && !empty) begin
                    pop    = 1'b1;
                    vld_d  = 1'b1;
                    data_d = rdata[DATA_LSB +: 8];
                    sop_d  = 1'b1;
                    eop_d  = is_last;
                    err_d  = is_last && rdata[ERR_BIT];
                    if (!is_last) state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (tx_r_rd) begin
                    if (!empty) begin
                        pop    = 1'b1;
                        vld_d  = 1'b1;
                        data_d = rdata[DATA_LSB +: 8];
                        eop_d  = is_last;
                        err_d  = is_last && rdata[ERR_BIT];
                        if (is_last) state_d = ST_IDLE;
                    end
`ifdef FROM_AXIS_CUT_THROUGH_EN
                    else begin
                        vld_d   = 1'b1;
                        uf_d    = 1'b1;
                        state_d = ST_FLUSH;
                    end
`endif
                end
            end
            ST_FLUSH: begin
                if (!empty) begin
                    pop = 1'b1;
                    if (is_last) begin
                        fl_d    = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        case ({frame_end, pop && is_last})
            2'b10:   frame_cnt_d = frame_cnt_q + LW'(1);
            2'b01:   frame_cnt_d = frame_cnt_q - LW'(1);
            default: frame_cnt_d = frame_cnt_q;
        endcase
        data_rdy_d = (frame_cnt_d != '0);
`ifdef FROM_AXIS_CUT_THROUGH_EN
        if (level_nxt >= LW'(CT_THRESH)) data_rdy_d = 1'b1;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tready_q       <= 1'b1;
            open_q         <= 1'b0;
            err_stk_q      <= 1'b0;
            frame_cnt_q    <= '0;
            data_rdy_q     <= 1'b0;
            state_q        <= ST_IDLE;
            tx_r_valid     <= 1'b0;
            tx_r_data      <= '0;
            tx_r_sop       <= 1'b0;
            tx_r_eop       <= 1'b0;
            tx_r_err       <= 1'b0;
            tx_r_underflow <= 1'b0;
            tx_r_flushed   <= 1'b0;
        end else begin
            tready_q       <= tready_d;
            open_q         <= open_d;
            err_stk_q      <= err_stk_d;
            frame_cnt_q    <= frame_cnt_d;
            data_rdy_q     <= data_rdy_d;
            state_q        <= state_d;
            tx_r_valid     <= vld_d;
            tx_r_data      <= data_d;
            tx_r_sop       <= sop_d;
            tx_r_eop       <= eop_d;
            tx_r_err       <= err_d;
            tx_r_underflow <= uf_d;
            tx_r_flushed   <= fl_d;
        end
    end

    // Each captured status returns its toggle one cycle later, so back-to-back edges stay ordered.
    assign end_edge = dma_tx_end_tog ^ end_tog_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            end_tog_q      <= 1'b0;
            status_q       <= '0;
            status_valid_q <= 1'b0;
            status_tog_q   <= 1'b0;
        end else begin
            end_tog_q      <= dma_tx_end_tog;
            status_valid_q <= end_edge;
            if (end_edge)       status_q     <= tx_r_status;
            if (status_valid_q) status_tog_q <= ~status_tog_q;
        end
    end

    assign s_axis_tready     = tready_q;
    assign tx_r_data_rdy     = data_rdy_q;
    assign tx_r_control      = 1'b0;
    assign tx_status         = status_q;
    assign tx_status_valid   = status_valid_q;
    assign dma_tx_status_tog = status_tog_q;

endmodule

// File: tb/tb_from_axis_converter.sv
// Scoreboard bench for from_axis_converter; cut-through checks run when FROM_AXIS_CUT_THROUGH_EN is defined.
module tb_from_axis_converter;

    logic       clk, rst;
    logic [7:0] s_axis_tdata;
    logic       s_axis_tkeep, s_axis_tvalid, s_axis_tlast, s_axis_tuser, s_axis_tready;
    logic       tx_r_rd, tx_r_data_rdy, tx_r_valid;
    logic [7:0] tx_r_data;
    logic       tx_r_sop, tx_r_eop, tx_r_err, tx_r_underflow, tx_r_flushed, tx_r_control;
    logic       dma_tx_end_tog;
    logic [3:0] tx_r_status;
    logic       dma_tx_status_tog;
    logic [3:0] tx_status;
    logic       tx_status_valid;

    typedef struct packed {
        logic [7:0] d;
        logic       sop;
        logic       eop;
        logic       err;
        logic       uf;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;
    int   flush_cnt = 0;

    from_axis_converter #(.DEPTH(256), .CT_THRESH(64)) dut (
        .clk               (clk),
        .rst               (rst),
        .s_axis_tdata      (s_axis_tdata),
        .s_axis_tkeep      (s_axis_tkeep),
        .s_axis_tvalid     (s_axis_tvalid),
        .s_axis_tlast      (s_axis_tlast),
        .s_axis_tuser      (s_axis_tuser),
        .s_axis_tready     (s_axis_tready),
        .tx_r_rd           (tx_r_rd),
        .tx_r_data_rdy     (tx_r_data_rdy),
        .tx_r_valid        (tx_r_valid),
        .tx_r_data         (tx_r_data),
        .tx_r_sop          (tx_r_sop),
        .tx_r_eop          (tx_r_eop),
        .tx_r_err          (tx_r_err),
        .tx_r_underflow    (tx_r_underflow),
        .tx_r_flushed      (tx_r_flushed),
        .tx_r_control      (tx_r_control),
        .dma_tx_end_tog    (dma_tx_end_tog),
        .tx_r_status       (tx_r_status),
        .dma_tx_status_tog (dma_tx_status_tog),
        .tx_status         (tx_status),
        .tx_status_valid   (tx_status_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every byte the DUT presents must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst && tx_r_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_valid: got data %0h with no expected byte at %0t", tx_r_data, $time);
            end else begin
                mon_e = exp_q.pop_front();
                if ({tx_r_data, tx_r_sop, tx_r_eop, tx_r_err, tx_r_underflow} !== mon_e) begin
                    errors++;
                    $display("FAIL rd_byte: got d=%0h sop=%0b eop=%0b err=%0b uf=%0b expected d=%0h sop=%0b eop=%0b err=%0b uf=%0b",
                             tx_r_data, tx_r_sop, tx_r_eop, tx_r_err, tx_r_underflow,
                             mon_e.d, mon_e.sop, mon_e.eop, mon_e.err, mon_e.uf);
                end
            end
        end
    end

    always @(negedge clk) if (!rst && tx_r_flushed) flush_cnt++;

    task automatic beat(input logic [7:0] d, input logic l, input logic u, input logic k);
        bit acc;
        int n;
        @(negedge clk);
        s_axis_tdata = d; s_axis_tlast = l; s_axis_tuser = u; s_axis_tkeep = k; s_axis_tvalid = 1'b1;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 1000) begin
            acc = s_axis_tready;
            @(posedge clk);
            if (!acc) @(negedge clk);
            n++;
        end
        if (!acc) begin
            errors++;
            checks++;
            $display("FAIL beat_timeout: tready stayed %0b for %0d cycles", s_axis_tready, n);
        end
        #1 s_axis_tvalid = 1'b0;
    endtask

    task automatic send_frame(input int n, input logic [7:0] base, input int user_idx, input bit push_exp);
        bit sticky;
        exp_t e;
        sticky = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (i == user_idx) sticky = 1'b1;
            beat(base + 8'(i), i == n - 1, i == user_idx, 1'b1);
            if (push_exp) begin
                e = '{d: base + 8'(i), sop: i == 0, eop: i == n - 1, err: (i == n - 1) && sticky, uf: 1'b0};
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic gem_read(input int n);
        @(negedge clk);
        tx_r_rd = 1'b1;
        repeat (n) @(negedge clk);
        tx_r_rd = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic push_exp(input logic [7:0] d, input logic sop, input logic eop, input logic err, input logic uf);
        exp_t e;
        e = '{d: d, sop: sop, eop: eop, err: err, uf: uf};
        exp_q.push_back(e);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; s_axis_tdata = '0; s_axis_tkeep = 1'b1; s_axis_tvalid = 1'b0;
        s_axis_tlast = 1'b0; s_axis_tuser = 1'b0; tx_r_rd = 1'b0;
        dma_tx_end_tog = 1'b0; tx_r_status = '0;
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        @(negedge clk);

        // reset state
        check("rst_tready", s_axis_tready, 1);
        check("rst_data_rdy", tx_r_data_rdy, 0);
        check("rst_valid", tx_r_valid, 0);
        check("rst_status_valid", tx_status_valid, 0);
        check("rst_status_tog", dma_tx_status_tog, 0);
        check("rst_control", tx_r_control, 0);

        // read request with nothing stored is ignored
        @(negedge clk) tx_r_rd = 1'b1;
        @(posedge clk) #1 check("idle_rd_ignored", tx_r_valid, 0);
        @(negedge clk) tx_r_rd = 1'b0;

        // 64-byte frame: data_rdy rises right after the tlast write
        for (int i = 0; i < 63; i++) beat(8'(i), 1'b0, 1'b0, 1'b1);
        check("rdy_before_tlast", tx_r_data_rdy, 0);
        beat(8'd63, 1'b1, 1'b0, 1'b1);
        check("rdy_after_tlast", tx_r_data_rdy, 1);
        for (int i = 0; i < 64; i++) push_exp(8'(i), i == 0, i == 63, 1'b0, 1'b0);
        gem_read(64);
        check("f64_drained", exp_q.size(), 0);
        check("f64_rdy_cleared", tx_r_data_rdy, 0);

        // tuser on byte 10 of 20: err only on eop
        send_frame(20, 8'h80, 9, 1'b1);
        gem_read(20);
        check("err_drained", exp_q.size(), 0);

        // tkeep=0 mid-frame dropped; tkeep=0 tlast closes the frame on the previous entry
        beat(8'hA0, 1'b0, 1'b0, 1'b1);
        beat(8'hA1, 1'b0, 1'b0, 1'b1);
        beat(8'hEE, 1'b0, 1'b0, 1'b0);
        beat(8'hA2, 1'b0, 1'b0, 1'b1);
        beat(8'hEF, 1'b1, 1'b1, 1'b0);
        check("merge_rdy", tx_r_data_rdy, 1);
        push_exp(8'hA0, 1, 0, 0, 0);
        push_exp(8'hA1, 0, 0, 0, 0);
        push_exp(8'hA2, 0, 1, 1, 0);
        gem_read(3);
        check("merge_drained", exp_q.size(), 0);
        beat(8'hEF, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        check("orphan_tlast_dropped", tx_r_data_rdy, 0);

        // full at 256 bytes, one pop reopens tready next cycle
        for (int i = 0; i < 255; i++) beat(8'(i), 1'b0, 1'b0, 1'b1);
        check("tready_at_255", s_axis_tready, 1);
        beat(8'hFF, 1'b1, 1'b0, 1'b1);
        check("tready_at_256", s_axis_tready, 0);
        for (int i = 0; i < 256; i++) push_exp(8'(i), i == 0, i == 255, 1'b0, 1'b0);
        @(negedge clk) tx_r_rd = 1'b1;
        @(posedge clk) #1 check("tready_after_pop", s_axis_tready, 1);
        @(negedge clk);
        repeat (255) @(negedge clk);
        tx_r_rd = 1'b0;
        repeat (3) @(negedge clk);
        check("full_drained", exp_q.size(), 0);

        // status handshake, single then back-to-back edges
        @(negedge clk) begin dma_tx_end_tog = 1'b1; tx_r_status = 4'hA; end
        @(posedge clk) #1;
        check("st_value", tx_status, 4'hA);
        check("st_valid", tx_status_valid, 1);
        check("st_tog_not_yet", dma_tx_status_tog, 0);
        @(posedge clk) #1;
        check("st_valid_pulse", tx_status_valid, 0);
        check("st_tog", dma_tx_status_tog, 1);
        @(negedge clk) begin dma_tx_end_tog = 1'b0; tx_r_status = 4'h5; end
        @(negedge clk) begin dma_tx_end_tog = 1'b1; tx_r_status = 4'h3; end
        check("st_b2b_first", {tx_status_valid, tx_status}, 5'h15);
        @(negedge clk);
        check("st_b2b_second", {tx_status_valid, tx_status}, 5'h13);
        check("st_b2b_tog1", dma_tx_status_tog, 0);
        @(negedge clk);
        check("st_b2b_tog2", dma_tx_status_tog, 1);

        // reset in the middle of sending with two frames queued
        send_frame(8, 8'h30, -1, 1'b0);
        send_frame(8, 8'h50, -1, 1'b0);
        push_exp(8'h30, 1, 0, 0, 0);
        push_exp(8'h31, 0, 0, 0, 0);
        push_exp(8'h32, 0, 0, 0, 0);
        gem_read(3);
        check("pre_rst_drained", exp_q.size(), 0);
        @(negedge clk) rst = 1'b1;
        @(posedge clk) #1;
        check("midrst_data_rdy", tx_r_data_rdy, 0);
        check("midrst_valid", tx_r_valid, 0);
        @(negedge clk) rst = 1'b0;
        @(negedge clk) tx_r_rd = 1'b1;
        @(posedge clk) #1 check("midrst_empty", tx_r_valid, 0);
        @(negedge clk) tx_r_rd = 1'b0;
        send_frame(4, 8'hC0, -1, 1'b1);
        gem_read(4);
        check("post_rst_drained", exp_q.size(), 0);

`ifdef FROM_AXIS_CUT_THROUGH_EN
        // cut-through: read one past the stored bytes, the remainder of the frame is flushed
        for (int i = 0; i < 64; i++) beat(8'h40 + 8'(i), 1'b0, 1'b0, 1'b1);
        check("ct_rdy", tx_r_data_rdy, 1);
        for (int i = 0; i < 64; i++) push_exp(8'h40 + 8'(i), i == 0, 1'b0, 1'b0, 1'b0);
        push_exp(8'h00, 0, 0, 0, 1);
        gem_read(65);
        check("ct_drained", exp_q.size(), 0);
        check("ct_no_early_flush", flush_cnt, 0);
        send_frame(10, 8'h90, -1, 1'b0);
        repeat (10) @(negedge clk);
        check("ct_flushed", flush_cnt, 1);
        check("ct_rdy_cleared", tx_r_data_rdy, 0);
`else
        check("no_flush", flush_cnt, 0);
`endif

        repeat (5) @(negedge clk);
        check("final_queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
